// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-client I2C arbiter.
// Holds the arbiter FSM state encoding, the client count and the
// round-robin grant helper used by the top level.
package i2c_arb_pkg;

   localparam int NCLIENT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } arb_state_t;

   // Picks the client to serve. On a tie, the client that was not served
   // last gets the bus, so neither client can starve the other.
   function automatic logic pick_grant(input logic pend0,
                                       input logic pend1,
                                       input logic last_grant);
      logic grant;
      if (pend0 && pend1) begin
         grant = ~last_grant;
      end else if (pend1) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
      return grant;
   endfunction

endpackage

// File: rtl/i2c_arb_req.sv
// Per-client request holder for the I2C arbiter.
// Captures one client's transaction fields on an exec pulse and keeps the
// busy flag set until the arbiter finishes (done or timeout) the request.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   exec              client request pulse, fields valid in the same cycle
//   rh_wl .. reg_num  transaction fields from the client
//   clear             arbiter finished this client's request
//   busy              request pending or in service
//   lat_*             latched copy of the fields
module i2c_arb_req #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             exec,
   input  logic             rh_wl,
   input  logic [6:0]       slave_addr,
   input  logic [15:0]      addr,
   input  logic [7:0]       data_w,
   input  logic             bit_ctrl,
   input  logic [WIDTH-1:0] reg_num,
   input  logic             clear,
   output logic             busy,
   output logic             lat_rh_wl,
   output logic [6:0]       lat_slave_addr,
   output logic [15:0]      lat_addr,
   output logic [7:0]       lat_data_w,
   output logic             lat_bit_ctrl,
   output logic [WIDTH-1:0] lat_reg_num
);

   // Fields are only captured while idle, so a repeated exec from a busy
   // client can never corrupt the request already queued or on the bus.
   // clear only ever arrives while busy, so it never races a new capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy           <= 1'b0;
         lat_rh_wl      <= 1'b0;
         lat_slave_addr <= '0;
         lat_addr       <= '0;
         lat_data_w     <= '0;
         lat_bit_ctrl   <= 1'b0;
         lat_reg_num    <= '0;
      end else if (exec && !busy) begin
         busy           <= 1'b1;
         lat_rh_wl      <= rh_wl;
         lat_slave_addr <= slave_addr;
         lat_addr       <= addr;
         lat_data_w     <= data_w;
         lat_bit_ctrl   <= bit_ctrl;
         lat_reg_num    <= reg_num;
      end else if (clear) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: rtl/i2c_arb.sv
// Two-client arbiter in front of a single i2c_dri master.
// Each client posts a request with cN_exec; requests are queued per client,
// granted round-robin, issued to the master with a one-cycle m_exec, and
// the master's per-byte results are routed back to the owning client only.
// A stuck transaction is aborted after TIMEOUT_CYC cycles; the arbiter then
// flushes for up to another TIMEOUT_CYC cycles so a late m_done from the
// aborted transfer cannot be credited to the next client.
// Ports:
//   clk, rst_n              clock (dri_clk domain), async active-low reset
//   cN_exec .. cN_reg_num   client N request fields
//   cN_data_r/byte_done/ack client N view of master results (owner only)
//   cN_done, cN_timeout     completion / abort pulses
//   cN_busy                 request pending or in service
//   m_*                     master request fields out, results in
module i2c_arb
   import i2c_arb_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             c0_exec,
   input  logic             c0_rh_wl,
   input  logic [6:0]       c0_slave_addr,
   input  logic [15:0]      c0_addr,
   input  logic [7:0]       c0_data_w,
   input  logic             c0_bit_ctrl,
   input  logic [WIDTH-1:0] c0_reg_num,
   output logic [7:0]       c0_data_r,
   output logic             c0_byte_done,
   output logic             c0_ack,
   output logic             c0_done,
   output logic             c0_busy,
   output logic             c0_timeout,
   input  logic             c1_exec,
   input  logic             c1_rh_wl,
   input  logic [6:0]       c1_slave_addr,
   input  logic [15:0]      c1_addr,
   input  logic [7:0]       c1_data_w,
   input  logic             c1_bit_ctrl,
   input  logic [WIDTH-1:0] c1_reg_num,
   output logic [7:0]       c1_data_r,
   output logic             c1_byte_done,
   output logic             c1_ack,
   output logic             c1_done,
   output logic             c1_busy,
   output logic             c1_timeout,
   output logic             m_exec,
   output logic             m_rh_wl,
   output logic [6:0]       m_slave_addr,
   output logic [15:0]      m_addr,
   output logic [7:0]       m_data_w,
   output logic             m_bit_ctrl,
   output logic [WIDTH-1:0] m_reg_num,
   input  logic [7:0]       m_data_r,
   input  logic             m_byte_done,
   input  logic             m_ack,
   input  logic             m_done
);

   localparam int            CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   arb_state_t           state, state_d;
   logic                 owner, owner_d;
   logic                 last_grant, last_grant_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [NCLIENT-1:0]   busy;
   logic [NCLIENT-1:0]   clear;

   logic                 l0_rh_wl, l1_rh_wl;
   logic [6:0]           l0_slave_addr, l1_slave_addr;
   logic [15:0]          l0_addr, l1_addr;
   logic [7:0]           l0_data_w, l1_data_w;
   logic                 l0_bit_ctrl, l1_bit_ctrl;
   logic [WIDTH-1:0]     l0_reg_num, l1_reg_num;

   i2c_arb_req #(.WIDTH(WIDTH)) u_req0 (
      .clk            (clk),
      .rst_n          (rst_n),
      .exec           (c0_exec),
      .rh_wl          (c0_rh_wl),
      .slave_addr     (c0_slave_addr),
      .addr           (c0_addr),
      .data_w         (c0_data_w),
      .bit_ctrl       (c0_bit_ctrl),
      .reg_num        (c0_reg_num),
      .clear          (clear[0]),
      .busy           (busy[0]),
      .lat_rh_wl      (l0_rh_wl),
      .lat_slave_addr (l0_slave_addr),
      .lat_addr       (l0_addr),
      .lat_data_w     (l0_data_w),
      .lat_bit_ctrl   (l0_bit_ctrl),
      .lat_reg_num    (l0_reg_num)
   );

   i2c_arb_req #(.WIDTH(WIDTH)) u_req1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .exec           (c1_exec),
      .rh_wl          (c1_rh_wl),
      .slave_addr     (c1_slave_addr),
      .addr           (c1_addr),
      .data_w         (c1_data_w),
      .bit_ctrl       (c1_bit_ctrl),
      .reg_num        (c1_reg_num),
      .clear          (clear[1]),
      .busy           (busy[1]),
      .lat_rh_wl      (l1_rh_wl),
      .lat_slave_addr (l1_slave_addr),
      .lat_addr       (l1_addr),
      .lat_data_w     (l1_data_w),
      .lat_bit_ctrl   (l1_bit_ctrl),
      .lat_reg_num    (l1_reg_num)
   );

   assign c0_busy = busy[0];
   assign c1_busy = busy[1];

   // State, owner, round-robin history and the WAIT/FLUSH cycle counter.
   // last_grant starts at 1 so client 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         last_grant <= last_grant_d;
         cnt        <= cnt_d;
      end
   end

   // Next-state logic plus all routing. The master only sees the owner's
   // request while ISSUE/WAIT are active; results and done travel back
   // combinationally during WAIT so the client sees m_done on the same
   // edge the master reports it. FLUSH routes nothing: whatever the master
   // still produces belongs to an aborted transfer.
   always_comb begin
      state_d      = state;
      owner_d      = owner;
      last_grant_d = last_grant;
      cnt_d        = cnt;
      clear        = '0;

      m_exec       = 1'b0;
      m_rh_wl      = 1'b0;
      m_slave_addr = '0;
      m_addr       = '0;
      m_data_w     = '0;
      m_bit_ctrl   = 1'b0;
      m_reg_num    = '0;

      c0_data_r    = '0;
      c0_byte_done = 1'b0;
      c0_ack       = 1'b0;
      c0_done      = 1'b0;
      c0_timeout   = 1'b0;
      c1_data_r    = '0;
      c1_byte_done = 1'b0;
      c1_ack       = 1'b0;
      c1_done      = 1'b0;
      c1_timeout   = 1'b0;

      if (state == ISSUE || state == WAIT) begin
         m_rh_wl      = owner ? l1_rh_wl      : l0_rh_wl;
         m_slave_addr = owner ? l1_slave_addr : l0_slave_addr;
         m_addr       = owner ? l1_addr       : l0_addr;
         m_data_w     = owner ? l1_data_w     : l0_data_w;
         m_bit_ctrl   = owner ? l1_bit_ctrl   : l0_bit_ctrl;
         m_reg_num    = owner ? l1_reg_num    : l0_reg_num;
      end

      case (state)
         IDLE: begin
            if (|busy) begin
               owner_d = pick_grant(busy[0], busy[1], last_grant);
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            m_exec  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            if (owner) begin
               c1_data_r    = m_data_r;
               c1_byte_done = m_byte_done;
               c1_ack       = m_ack;
               c1_done      = m_done;
            end else begin
               c0_data_r    = m_data_r;
               c0_byte_done = m_byte_done;
               c0_ack       = m_ack;
               c0_done      = m_done;
            end

            if (m_done) begin
               clear[owner] = 1'b1;
               last_grant_d = owner;
               state_d      = IDLE;
            end else if (cnt == CNT_LAST) begin
               c0_timeout   = ~owner;
               c1_timeout   = owner;
               clear[owner] = 1'b1;
               last_grant_d = owner;
               cnt_d        = '0;
               state_d      = FLUSH;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end

         FLUSH: begin
            if (m_done || cnt == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_arb.sv
// Directed testbench for i2c_arb.
// Instance dut uses the default timeout; instance dut_to uses a 16-cycle
// timeout and is held in reset except for the abort scenario. Both share
// the same stimulus nets. Stimulus is applied and outputs sampled 1 time
// unit after the rising edge.
module tb_i2c_arb;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             rst_n_b = 1'b0;

   logic             c0_exec = 0, c0_rh_wl = 0, c0_bit_ctrl = 0;
   logic [6:0]       c0_slave_addr = 0;
   logic [15:0]      c0_addr = 0;
   logic [7:0]       c0_data_w = 0;
   logic [WIDTH-1:0] c0_reg_num = 0;
   logic             c1_exec = 0, c1_rh_wl = 0, c1_bit_ctrl = 0;
   logic [6:0]       c1_slave_addr = 0;
   logic [15:0]      c1_addr = 0;
   logic [7:0]       c1_data_w = 0;
   logic [WIDTH-1:0] c1_reg_num = 0;
   logic [7:0]       m_data_r = 0;
   logic             m_byte_done = 0, m_ack = 0, m_done = 0;

   logic [7:0]       c0_data_r, c1_data_r;
   logic             c0_byte_done, c0_ack, c0_done, c0_busy, c0_timeout;
   logic             c1_byte_done, c1_ack, c1_done, c1_busy, c1_timeout;
   logic             m_exec, m_rh_wl, m_bit_ctrl;
   logic [6:0]       m_slave_addr;
   logic [15:0]      m_addr;
   logic [7:0]       m_data_w;
   logic [WIDTH-1:0] m_reg_num;

   logic [7:0]       b_c0_data_r, b_c1_data_r;
   logic             b_c0_byte_done, b_c0_ack, b_c0_done, b_c0_busy, b_c0_timeout;
   logic             b_c1_byte_done, b_c1_ack, b_c1_done, b_c1_busy, b_c1_timeout;
   logic             b_m_exec, b_m_rh_wl, b_m_bit_ctrl;
   logic [6:0]       b_m_slave_addr;
   logic [15:0]      b_m_addr;
   logic [7:0]       b_m_data_w;
   logic [WIDTH-1:0] b_m_reg_num;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   i2c_arb #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_exec(c0_exec), .c0_rh_wl(c0_rh_wl), .c0_slave_addr(c0_slave_addr),
      .c0_addr(c0_addr), .c0_data_w(c0_data_w), .c0_bit_ctrl(c0_bit_ctrl),
      .c0_reg_num(c0_reg_num), .c0_data_r(c0_data_r), .c0_byte_done(c0_byte_done),
      .c0_ack(c0_ack), .c0_done(c0_done), .c0_busy(c0_busy), .c0_timeout(c0_timeout),
      .c1_exec(c1_exec), .c1_rh_wl(c1_rh_wl), .c1_slave_addr(c1_slave_addr),
      .c1_addr(c1_addr), .c1_data_w(c1_data_w), .c1_bit_ctrl(c1_bit_ctrl),
      .c1_reg_num(c1_reg_num), .c1_data_r(c1_data_r), .c1_byte_done(c1_byte_done),
      .c1_ack(c1_ack), .c1_done(c1_done), .c1_busy(c1_busy), .c1_timeout(c1_timeout),
      .m_exec(m_exec), .m_rh_wl(m_rh_wl), .m_slave_addr(m_slave_addr),
      .m_addr(m_addr), .m_data_w(m_data_w), .m_bit_ctrl(m_bit_ctrl),
      .m_reg_num(m_reg_num), .m_data_r(m_data_r), .m_byte_done(m_byte_done),
      .m_ack(m_ack), .m_done(m_done)
   );

   i2c_arb #(.WIDTH(WIDTH), .TIMEOUT_CYC(16)) dut_to (
      .clk(clk), .rst_n(rst_n_b),
      .c0_exec(c0_exec), .c0_rh_wl(c0_rh_wl), .c0_slave_addr(c0_slave_addr),
      .c0_addr(c0_addr), .c0_data_w(c0_data_w), .c0_bit_ctrl(c0_bit_ctrl),
      .c0_reg_num(c0_reg_num), .c0_data_r(b_c0_data_r), .c0_byte_done(b_c0_byte_done),
      .c0_ack(b_c0_ack), .c0_done(b_c0_done), .c0_busy(b_c0_busy), .c0_timeout(b_c0_timeout),
      .c1_exec(c1_exec), .c1_rh_wl(c1_rh_wl), .c1_slave_addr(c1_slave_addr),
      .c1_addr(c1_addr), .c1_data_w(c1_data_w), .c1_bit_ctrl(c1_bit_ctrl),
      .c1_reg_num(c1_reg_num), .c1_data_r(b_c1_data_r), .c1_byte_done(b_c1_byte_done),
      .c1_ack(b_c1_ack), .c1_done(b_c1_done), .c1_busy(b_c1_busy), .c1_timeout(b_c1_timeout),
      .m_exec(b_m_exec), .m_rh_wl(b_m_rh_wl), .m_slave_addr(b_m_slave_addr),
      .m_addr(b_m_addr), .m_data_w(b_m_data_w), .m_bit_ctrl(b_m_bit_ctrl),
      .m_reg_num(b_m_reg_num), .m_data_r(m_data_r), .m_byte_done(m_byte_done),
      .m_ack(m_ack), .m_done(m_done)
   );

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads one client's request fields and raises its exec.
   task automatic setReq(input int client, input logic rh, input logic [6:0] sa,
                         input logic [15:0] ad, input logic [7:0] dw,
                         input logic bc, input logic [WIDTH-1:0] rn);
      if (client == 0) begin
         c0_exec = 1; c0_rh_wl = rh; c0_slave_addr = sa; c0_addr = ad;
         c0_data_w = dw; c0_bit_ctrl = bc; c0_reg_num = rn;
      end else begin
         c1_exec = 1; c1_rh_wl = rh; c1_slave_addr = sa; c1_addr = ad;
         c1_data_w = dw; c1_bit_ctrl = bc; c1_reg_num = rn;
      end
   endtask

   // Lets the exec pulses be sampled on the next edge, then drops them.
   task automatic fire();
      tick();
      c0_exec = 0;
      c1_exec = 0;
   endtask

   task automatic applyStimulus(input int client, input logic rh, input logic [6:0] sa,
                                input logic [15:0] ad, input logic [7:0] dw,
                                input logic bc, input logic [WIDTH-1:0] rn);
      setReq(client, rh, sa, ad, dw, bc, rn);
      fire();
   endtask

   // Master reports completion with a result byte; checks routing to the
   // expected owner, then lets the done be sampled on the next edge.
   task automatic pulseDone(input string tag, input logic exp0, input logic exp1);
      m_done = 1; m_data_r = 8'h5A; m_byte_done = 1; m_ack = 1;
      #1;
      checkOutput({tag, " c0_done"}, c0_done, exp0);
      checkOutput({tag, " c1_done"}, c1_done, exp1);
      checkOutput({tag, " c0_data_r"}, c0_data_r, exp0 ? 8'h5A : 8'h00);
      checkOutput({tag, " c1_data_r"}, c1_data_r, exp1 ? 8'h5A : 8'h00);
      checkOutput({tag, " c1_ack"}, c1_ack, exp1);
      @(posedge clk);
      #1;
      m_done = 0; m_data_r = 0; m_byte_done = 0; m_ack = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;

      // Reset state
      #12;
      checkOutput("rst c0_busy", c0_busy, 0);
      checkOutput("rst m_exec", m_exec, 0);
      checkOutput("rst m_addr", m_addr, 0);
      checkOutput("rst c1_data_r", c1_data_r, 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick();

      // Simultaneous requests after reset: c0 wins, c1 follows
      setReq(0, 0, 7'h20, 16'h0010, 8'h11, 0, 8'd1);
      setReq(1, 1, 7'h31, 16'h0020, 8'h22, 0, 8'd2);
      fire();
      checkOutput("tie c0_busy", c0_busy, 1);
      checkOutput("tie c1_busy", c1_busy, 1);
      tick();
      checkOutput("tie m_exec c0", m_exec, 1);
      checkOutput("tie m_slave c0", m_slave_addr, 7'h20);
      tick();
      pulseDone("tie c0", 1, 0);
      checkOutput("tie c0_busy clr", c0_busy, 0);
      checkOutput("tie idle m_exec", m_exec, 0);
      tick();
      checkOutput("tie m_exec c1", m_exec, 1);
      checkOutput("tie m_slave c1", m_slave_addr, 7'h31);
      checkOutput("tie m_reg_num c1", m_reg_num, 8'd2);
      tick();
      pulseDone("tie c1", 0, 1);
      // last_grant is now 1: another tie must again go to c0
      setReq(0, 0, 7'h22, 16'h0011, 8'h12, 0, 8'd1);
      setReq(1, 0, 7'h33, 16'h0021, 8'h23, 0, 8'd1);
      fire();
      tick();
      checkOutput("tie2 m_slave c0", m_slave_addr, 7'h22);
      tick();
      pulseDone("tie2 c0", 1, 0);
      tick();
      checkOutput("tie2 m_slave c1", m_slave_addr, 7'h33);
      tick();
      pulseDone("tie2 c1", 0, 1);

      // Single c0 read, m_done 20 cycles after m_exec
      applyStimulus(0, 1, 7'h14, 16'h814E, 8'h00, 1, 8'd1);
      checkOutput("rd c0_busy", c0_busy, 1);
      checkOutput("rd m_exec early", m_exec, 0);
      tick();
      checkOutput("rd m_exec", m_exec, 1);
      checkOutput("rd m_addr", m_addr, 16'h814E);
      checkOutput("rd m_slave", m_slave_addr, 7'h14);
      checkOutput("rd m_rh_wl", m_rh_wl, 1);
      checkOutput("rd m_bit_ctrl", m_bit_ctrl, 1);
      tick();
      checkOutput("rd m_exec 1cyc", m_exec, 0);
      checkOutput("rd m_addr wait", m_addr, 16'h814E);
      repeat (19) tick();
      checkOutput("rd c0_done early", c0_done, 0);
      checkOutput("rd c1_busy", c1_busy, 0);
      pulseDone("rd", 1, 0);
      checkOutput("rd c0_busy clr", c0_busy, 0);
      checkOutput("rd m_addr idle", m_addr, 0);
      // Stray m_done while idle is ignored
      m_done = 1;
      #1;
      checkOutput("idle m_done c0_done", c0_done, 0);
      m_done = 0;
      tick();

      // c1 arrives during c0 WAIT, c0 re-requests right after its done
      applyStimulus(0, 0, 7'h40, 16'h0040, 8'h44, 0, 8'd1);
      tick();
      checkOutput("rr m_slave c0", m_slave_addr, 7'h40);
      tick();
      applyStimulus(1, 0, 7'h41, 16'h0041, 8'h45, 0, 8'd1);
      checkOutput("rr c1_busy", c1_busy, 1);
      pulseDone("rr c0", 1, 0);
      applyStimulus(0, 0, 7'h42, 16'h0042, 8'h46, 0, 8'd1);
      checkOutput("rr m_exec c1", m_exec, 1);
      checkOutput("rr m_slave c1", m_slave_addr, 7'h41);
      tick();
      pulseDone("rr c1", 0, 1);
      tick();
      checkOutput("rr m_slave c0 again", m_slave_addr, 7'h42);
      tick();
      pulseDone("rr c0b", 1, 0);

      // Re-exec while busy must be ignored
      applyStimulus(0, 0, 7'h50, 16'h0050, 8'h55, 0, 8'd1);
      applyStimulus(0, 0, 7'h5F, 16'h005F, 8'hAA, 0, 8'd1);
      checkOutput("ign m_data_w", m_data_w, 8'h55);
      checkOutput("ign m_slave", m_slave_addr, 7'h50);
      tick();
      checkOutput("ign m_data_w wait", m_data_w, 8'h55);
      pulseDone("ign", 1, 0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (m_exec) n++;
         tick();
      end
      checkOutput("ign no extra exec", n, 0);
      checkOutput("ign c0_busy", c0_busy, 0);

      // Reset mid-WAIT
      applyStimulus(0, 0, 7'h60, 16'h1234, 8'h77, 0, 8'd1);
      tick();
      tick();
      m_data_r = 8'hC3; m_ack = 1;
      #1;
      checkOutput("rw c0_data_r", c0_data_r, 8'hC3);
      rst_n = 0;
      #1;
      checkOutput("rw rst c0_data_r", c0_data_r, 0);
      checkOutput("rw rst c0_ack", c0_ack, 0);
      checkOutput("rw rst c0_busy", c0_busy, 0);
      checkOutput("rw rst m_slave", m_slave_addr, 0);
      m_done = 1;
      #1;
      checkOutput("rw rst c0_done", c0_done, 0);
      checkOutput("rw rst c0_timeout", c0_timeout, 0);
      m_done = 0; m_data_r = 0; m_ack = 0;
      tick();
      rst_n = 1;
      tick();
      applyStimulus(1, 0, 7'h61, 16'h0061, 8'h01, 0, 8'd1);
      tick();
      checkOutput("rw post m_exec", m_exec, 1);
      checkOutput("rw post m_slave", m_slave_addr, 7'h61);
      tick();
      pulseDone("rw post", 0, 1);

      // Timeout with TIMEOUT_CYC=16 on dut_to; dut held in reset
      rst_n = 0;
      rst_n_b = 1;
      tick();
      applyStimulus(0, 0, 7'h70, 16'h0070, 8'h07, 0, 8'd1);
      applyStimulus(1, 0, 7'h71, 16'h0071, 8'h08, 0, 8'd1);
      checkOutput("to m_exec c0", b_m_exec, 1);
      checkOutput("to m_slave c0", b_m_slave_addr, 7'h70);
      n = 0;
      while (!b_c0_timeout && n < 40) begin
         tick();
         n++;
      end
      checkOutput("to cycles to timeout", n, 16);
      checkOutput("to c0_done", b_c0_done, 0);
      checkOutput("to c1_timeout", b_c1_timeout, 0);
      m_data_r = 8'hEE; m_ack = 1; m_byte_done = 1;
      tick();
      checkOutput("to pulse width", b_c0_timeout, 0);
      checkOutput("to c0_busy clr", b_c0_busy, 0);
      checkOutput("to c1_busy", b_c1_busy, 1);
      checkOutput("flush c0_data_r", b_c0_data_r, 0);
      checkOutput("flush c1_data_r", b_c1_data_r, 0);
      checkOutput("flush m_slave", b_m_slave_addr, 0);
      n = 0;
      while (!b_m_exec && n < 40) begin
         tick();
         n++;
      end
      m_data_r = 0; m_ack = 0; m_byte_done = 0;
      checkOutput("flush cycles to c1 exec", n, 17);
      checkOutput("flush m_slave c1", b_m_slave_addr, 7'h71);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter WIDTH, default 8: width of reg_num on all ports.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles allowed per transaction before abort.
REQ-003 clk  input  1  drive clock (i2c_dri dri_clk domain).
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 c0_exec, c1_exec  input  1  client request pulse; the client's fields below are valid in the same cycle.
REQ-006 c0_rh_wl, c1_rh_wl  input  1  1=read, 0=write.
REQ-007 c0_slave_addr, c1_slave_addr  input  7  device address.
REQ-008 c0_addr, c1_addr  input  16  register address.
REQ-009 c0_data_w, c1_data_w  input  8  write data.
REQ-010 c0_bit_ctrl, c1_bit_ctrl  input  1  0=8-bit, 1=16-bit register address.
REQ-011 c0_reg_num, c1_reg_num  input  WIDTH  register count.
REQ-012 c0_data_r, c1_data_r  output  8  read byte, routed from master.
REQ-013 c0_byte_done, c1_byte_done  output  1  per-byte strobe, routed.
REQ-014 c0_ack, c1_ack  output  1  ack flag, routed.
REQ-015 c0_done, c1_done  output  1  transaction-complete pulse.
REQ-016 c0_busy, c1_busy  output  1  request pending or in service.
REQ-017 c0_timeout, c1_timeout  output  1  one-cycle abort pulse.
REQ-018 m_exec, m_rh_wl, m_slave_addr, m_addr, m_data_w, m_bit_ctrl, m_reg_num  output  1/1/7/16/8/1/WIDTH  to i2c_dri.
REQ-019 m_data_r, m_byte_done, m_ack, m_done  input  8/1/1/1  from i2c_dri.

Function
REQ-020 When cN_exec is sampled high with cN_busy low, the block SHALL latch all cN fields and set cN_busy on the next edge.
REQ-021 When cN_exec is sampled high with cN_busy high, the block SHALL ignore it without altering the latched fields.
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and FLUSH.
REQ-023 In IDLE with at least one client pending, the FSM SHALL grant one client, register owner and go to ISSUE.
REQ-024 When both clients are pending, the grant SHALL go to the client other than last_grant (round-robin).
REQ-025 ISSUE SHALL assert m_exec for exactly one cycle, then go to WAIT.
REQ-026 From an idle arbiter, m_exec SHALL assert 2 cycles after the cN_exec sample edge.
REQ-027 The m_* fields SHALL carry the owner's latched values from ISSUE through WAIT.
REQ-028 The m_* fields SHALL be 0 otherwise.
REQ-029 In WAIT, m_data_r, m_byte_done and m_ack SHALL pass combinationally to the owner only.
REQ-030 The non-owner's data_r, byte_done and ack SHALL read 0.
REQ-031 In WAIT, m_done SHALL pass combinationally as the owner's cN_done, with zero latency.
REQ-032 On that edge the block SHALL clear the owner's busy, update last_grant and return to IDLE.
REQ-033 A WAIT cycle counter SHALL reset on entry to WAIT.
REQ-034 When the counter reaches TIMEOUT_CYC-1 without m_done, the block SHALL pulse the owner's cN_timeout, clear its busy, update last_grant and go to FLUSH.
REQ-035 FLUSH SHALL suppress all routing to clients.
REQ-036 FLUSH SHALL exit to IDLE on m_done or after another TIMEOUT_CYC cycles.
REQ-037 The non-owner SHALL be able to latch a new request in any state.
REQ-038 The owner SHALL be able to re-latch only after its busy clears.
REQ-039 An m_done outside WAIT and FLUSH SHALL be ignored.

Reset
REQ-040 On rst_n low, asynchronously: state=IDLE, last_grant=1 (c0 wins the first tie), busy=0, counter=0, latched fields=0.
REQ-041 On rst_n low, all outputs SHALL read 0.
REQ-042 Reset during WAIT SHALL abandon the transaction with no done or timeout pulse.

Structure
REQ-043 Package i2c_arb_pkg SHALL hold the state encodings and the constant NCLIENT=2.
REQ-044 Sub-module i2c_arb_req SHALL implement the per-client field latch and busy flag, instantiated twice.

Verification
REQ-045 c0 read request (addr 16'h814E, slave 7'h14, reg_num 1), m_done 20 cycles after m_exec -> m_exec 2 cycles after request, c0_done coincides with m_done, c0_busy falls, c1 outputs stay 0.
REQ-046 c0 and c1 exec in the same cycle after reset -> c0 served first; c1 m_exec 2 cycles after c0_done; last_grant=1.
REQ-047 c1 exec during c0 WAIT, then c0 re-exec immediately after c0_done -> c1 granted next (round-robin).
REQ-048 TIMEOUT_CYC=16, m_done never asserts -> c0_timeout pulses 16 cycles into WAIT, FLUSH holds 16 cycles, then pending c1 is issued.
REQ-049 Second c0_exec with data_w 8'hAA while c0 busy with 8'h55 -> m_data_w stays 8'h55, no extra transaction.
REQ-050 rst_n low mid-WAIT -> all outputs 0 immediately, no done or timeout pulse, next request issues normally.
